request_unit_gen: RTL and testbench

Parametrised per-core memory request unit with registered handshakes. It sits between a core's pipeline control (hazard/stall logic) and that core's caches. It generates imemREN/dmemREN/dmemWEN from ihit/dhit/MemRead/MemWrite/is_halted, and extends the single-cycle request unit with:
- a drain-then-halt sequence;
- a stuck-request watchdog;
- saturating performance counters for per-core profiling in the dual-core system.

---
 rtl/request_unit_gen_if.sv | 37 +++
 rtl/request_unit_gen.sv | 185 ++++++++++++++++++
 tb/tb_request_unit_gen.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/request_unit_gen_if.sv
// Handshake bundle between a core's pipeline control and caches (master side)
// and the per-core request unit (slave side).
interface request_unit_gen_if #(
    parameter int unsigned CNT_W = 32
);
    // Core/cache side to request unit
    logic ihit;
    logic dhit;
    logic MemRead;
    logic MemWrite;
    logic is_halted;

    // Request unit to core/cache side
    logic imemREN;
    logic dmemREN;
    logic dmemWEN;
    logic halted;
    logic timeout;

    // Profiling counters
    logic [CNT_W-1:0] ihit_cnt;
    logic [CNT_W-1:0] dhit_cnt;
    logic [CNT_W-1:0] istall_cnt;
    logic [CNT_W-1:0] dstall_cnt;

    modport master (
        output ihit, dhit, MemRead, MemWrite, is_halted,
        input  imemREN, dmemREN, dmemWEN, halted, timeout,
        input  ihit_cnt, dhit_cnt, istall_cnt, dstall_cnt
    );

    modport slave (
        input  ihit, dhit, MemRead, MemWrite, is_halted,
        output imemREN, dmemREN, dmemWEN, halted, timeout,
        output ihit_cnt, dhit_cnt, istall_cnt, dstall_cnt
    );
endinterface

// File: rtl/request_unit_gen.sv
// Per-core memory request unit: issues instruction/data requests, drains an
// outstanding data request before halting, flags stuck requests with a sticky
// watchdog and keeps saturating hit/stall counters for profiling.
// All outputs decode from registered state only.
module request_unit_gen #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic               CLK,
    input logic               RST,
    request_unit_gen_if.slave ru
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDreq = 2'd2,
        StHalt = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [TO_W-1:0]  WdOne   = TO_W'(1);
    localparam logic [TO_W-1:0]  WdLimit = TO_W'(TIMEOUT);

    state_e state_q, state_d;
    logic   is_write_q, is_write_d;      // latched type of the outstanding data request
    logic   halt_pend_q, halt_pend_d;    // halt seen while a data request was in flight

    logic [TO_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic [CNT_W-1:0] ihit_cnt_q, ihit_cnt_d;
    logic [CNT_W-1:0] dhit_cnt_q, dhit_cnt_d;
    logic [CNT_W-1:0] istall_cnt_q, istall_cnt_d;
    logic [CNT_W-1:0] dstall_cnt_q, dstall_cnt_d;

    logic imem_ren;
    logic dmem_ren;
    logic dmem_wen;
    logic halted;

    logic in_dreq;
    logic i_acc;
    logic d_acc;
    logic any_req;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + CntOne;
        end
        return v;
    endfunction

    // State and all registered bookkeeping; RST wins over every other update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            is_write_q   <= 1'b0;
            halt_pend_q  <= 1'b0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            ihit_cnt_q   <= '0;
            dhit_cnt_q   <= '0;
            istall_cnt_q <= '0;
            dstall_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            halt_pend_q  <= halt_pend_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            ihit_cnt_q   <= ihit_cnt_d;
            dhit_cnt_q   <= dhit_cnt_d;
            istall_cnt_q <= istall_cnt_d;
            dstall_cnt_q <= dstall_cnt_d;
        end
    end

    // Next-state logic: request sequencing and drain-then-halt.
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        halt_pend_d = halt_pend_q;
        unique case (state_q)
            StIdle: begin
                state_d = StRun;
            end
            StRun: begin
                // Store has priority over load when both are flagged.
                if (ru.MemWrite) begin
                    is_write_d = 1'b1;
                    state_d    = StDreq;
                end else if (ru.MemRead) begin
                    is_write_d = 1'b0;
                    state_d    = StDreq;
                end else if (ru.is_halted) begin
                    state_d = StHalt;
                end
            end
            StDreq: begin
                if (ru.is_halted) begin
                    halt_pend_d = 1'b1;
                end
                if (ru.dhit) begin
                    if (halt_pend_q || ru.is_halted) begin
                        state_d = StHalt;
                    end else begin
                        state_d     = StRun;
                        halt_pend_d = 1'b0;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        imem_ren = 1'b0;
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            StRun: begin
                imem_ren = 1'b1;
            end
            StDreq: begin
                imem_ren = 1'b1;
                dmem_wen = is_write_q;
                dmem_ren = ~is_write_q;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Accepted-hit and request-activity qualifiers shared by watchdog and counters.
    always_comb begin
        in_dreq = (state_q == StDreq);
        i_acc   = imem_ren & ru.ihit;
        d_acc   = in_dreq & ru.dhit;
        any_req = imem_ren | dmem_ren | dmem_wen;
    end

    // Watchdog: counts request cycles since the last accepted hit; timeout is sticky.
    always_comb begin
        wd_d = wd_q;
        if ((state_q == StIdle) || (state_q == StHalt) || i_acc || d_acc) begin
            wd_d = '0;
        end else if (any_req && (wd_q != '1)) begin
            wd_d = wd_q + WdOne;
        end
        // wd_d is zero whenever it was cleared, so only a counting edge can match.
        timeout_d = timeout_q | (wd_d == WdLimit);
    end

    // Profiling counters, each saturating.
    always_comb begin
        ihit_cnt_d   = sat_inc(ihit_cnt_q, i_acc);
        dhit_cnt_d   = sat_inc(dhit_cnt_q, d_acc);
        istall_cnt_d = sat_inc(istall_cnt_q, imem_ren & ~ru.ihit);
        dstall_cnt_d = sat_inc(dstall_cnt_q, in_dreq & ~ru.dhit);
    end

    assign ru.imemREN    = imem_ren;
    assign ru.dmemREN    = dmem_ren;
    assign ru.dmemWEN    = dmem_wen;
    assign ru.halted     = halted;
    assign ru.timeout    = timeout_q;
    assign ru.ihit_cnt   = ihit_cnt_q;
    assign ru.dhit_cnt   = dhit_cnt_q;
    assign ru.istall_cnt = istall_cnt_q;
    assign ru.dstall_cnt = dstall_cnt_q;

endmodule

// File: tb/tb_request_unit_gen.sv
// Scoreboard bench for request_unit_gen: stimulus pushes time-tagged expected
// output values; a monitor pops and compares them on the falling edge.
module tb_request_unit_gen;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TO_W    = 4;
    localparam int unsigned TIMEOUT = 8;

    typedef enum int {
        SigIren, SigDren, SigDwen, SigHalt, SigTo, SigIhc, SigDhc, SigIsc, SigDsc
    } sig_e;

    typedef struct {
        int    cyc;
        sig_e  sig;
        int    val;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    request_unit_gen_if #(.CNT_W(CNT_W)) bus ();

    request_unit_gen #(
        .CNT_W   (CNT_W),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .ru  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input sig_e s);
        case (s)
            SigIren: return int'(bus.imemREN);
            SigDren: return int'(bus.dmemREN);
            SigDwen: return int'(bus.dmemWEN);
            SigHalt: return int'(bus.halted);
            SigTo:   return int'(bus.timeout);
            SigIhc:  return int'(bus.ihit_cnt);
            SigDhc:  return int'(bus.dhit_cnt);
            SigIsc:  return int'(bus.istall_cnt);
            default: return int'(bus.dstall_cnt);
        endcase
    endfunction

    // Expect signal s to equal v off cycles from now (0 = current cycle).
    task automatic want(input int off, input sig_e s, input int v, input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = s;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: compare every expectation that has come due; a late one counts as failed.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    int act;
                    act = sample(sb[i].sig);
                    n_chk++;
                    if ((sb[i].cyc == cyc) && (act == sb[i].val)) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s cyc=%0d due=%0d actual=%0d required=%0d",
                                 sb[i].name, cyc, sb[i].cyc, act, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.ihit      = 1'b0;
        bus.dhit      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.is_halted = 1'b0;
        repeat (3) step();

        // Reset state
        want(0, SigIren, 0, "rst_iren");
        want(0, SigDren, 0, "rst_dren");
        want(0, SigDwen, 0, "rst_dwen");
        want(0, SigHalt, 0, "rst_halted");
        want(0, SigTo,   0, "rst_timeout");
        want(0, SigIhc,  0, "rst_ihit_cnt");
        want(0, SigDhc,  0, "rst_dhit_cnt");
        want(0, SigIsc,  0, "rst_istall_cnt");
        want(0, SigDsc,  0, "rst_dstall_cnt");
        rst = 1'b0;

        // Start-up with ihit in cycle 1 (ignored) and every even cycle
        for (int t = 1; t <= 10; t++) begin
            bus.ihit = (t == 1) || (t % 2 == 0);
            want(0, SigIren, (t >= 2) ? 1 : 0, "startup_iren");
            step();
        end
        want(0, SigIhc, 5, "startup_ihit_cnt");
        want(0, SigIsc, 4, "startup_istall_cnt");
        want(0, SigDhc, 0, "startup_dhit_cnt");
        bus.ihit = 1'b1;

        // ihit_cnt saturates at 15 with 4-bit counters (5 + 12 accepted hits)
        repeat (12) step();
        want(0, SigIhc, 15, "ihit_cnt_sat");
        want(0, SigIsc, 4, "istall_hold");

        // Load with three wait cycles; MemWrite raised mid-wait is ignored
        bus.MemRead = 1'b1;
        step();
        bus.MemRead = 1'b0;
        want(0, SigDren, 1, "ld_dren_c1");
        want(0, SigDwen, 0, "ld_dwen_c1");
        step();
        bus.MemWrite = 1'b1;
        want(0, SigDren, 1, "ld_dren_c2");
        step();
        want(0, SigDren, 1, "ld_dren_c3");
        want(0, SigDwen, 0, "ld_dwen_c3");
        step();
        bus.MemWrite = 1'b0;
        bus.dhit     = 1'b1;
        want(0, SigDren, 1, "ld_dren_c4");
        want(0, SigDwen, 0, "ld_dwen_c4");
        want(0, SigIren, 1, "ld_iren_c4");
        step();
        bus.dhit = 1'b0;
        want(0, SigDren, 0, "ld_dren_drop");
        want(0, SigDsc, 3, "ld_dstall_cnt");
        want(0, SigDhc, 1, "ld_dhit_cnt");
        step();

        // Load and store together: store wins
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b1;
        step();
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.dhit     = 1'b1;
        want(0, SigDwen, 1, "both_dwen");
        want(0, SigDren, 0, "both_dren");
        step();
        // Store immediately followed by a load
        bus.dhit     = 1'b0;
        bus.MemWrite = 1'b1;
        want(0, SigDwen, 0, "both_drop");
        step();
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        bus.dhit     = 1'b1;
        want(0, SigDwen, 1, "st_dwen");
        step();
        bus.dhit = 1'b0;
        want(0, SigDwen, 0, "gap_dwen");
        want(0, SigDren, 0, "gap_dren");
        step();
        bus.MemRead = 1'b0;
        bus.dhit    = 1'b1;
        want(0, SigDren, 1, "b2b_ld_dren");
        want(0, SigDwen, 0, "b2b_ld_dwen");
        step();
        bus.dhit = 1'b0;
        want(0, SigDren, 0, "b2b_ld_drop");
        want(0, SigDhc, 4, "b2b_dhit_cnt");
        want(0, SigDsc, 3, "b2b_dstall_cnt");
        step();

        // Watchdog: no ihit for 12 cycles; timeout after the 8th counting edge
        bus.ihit = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 7) want(0, SigTo, 0, "to_before");
            if (k == 8) want(0, SigTo, 1, "to_set");
            step();
        end
        bus.ihit = 1'b1;
        step();
        want(0, SigTo, 1, "to_sticky");
        want(0, SigIsc, 15, "istall_sat");
        step();

        // Halt raised during a load; drain on dhit then stop
        bus.MemRead = 1'b1;
        step();
        bus.MemRead   = 1'b0;
        bus.is_halted = 1'b1;
        want(0, SigIren, 1, "hd_iren_c1");
        want(0, SigDren, 1, "hd_dren_c1");
        step();
        bus.is_halted = 1'b0;
        want(0, SigIren, 1, "hd_iren_c2");
        want(0, SigHalt, 0, "hd_halt_c2");
        step();
        bus.dhit = 1'b1;
        want(0, SigIren, 1, "hd_iren_c3");
        want(0, SigHalt, 0, "hd_halt_c3");
        step();
        bus.dhit    = 1'b0;
        bus.MemRead = 1'b1;
        want(0, SigHalt, 1, "hd_halted");
        want(0, SigIren, 0, "hd_iren_off");
        want(0, SigDren, 0, "hd_dren_off");
        want(0, SigDwen, 0, "hd_dwen_off");
        want(0, SigDhc, 5, "hd_dhit_cnt");
        want(0, SigDsc, 5, "hd_dstall_cnt");
        step();
        bus.dhit = 1'b1;
        step();
        bus.dhit = 1'b0;
        repeat (2) step();
        want(0, SigHalt, 1, "halt_terminal");
        want(0, SigDren, 0, "halt_dren");
        want(0, SigIren, 0, "halt_iren");
        want(0, SigDhc, 5, "halt_dhit_cnt");
        bus.MemRead = 1'b0;

        // Reset out of HALT, then reset during an outstanding load
        rst = 1'b1;
        step();
        rst = 1'b0;
        want(0, SigTo, 0, "rst2_timeout");
        want(0, SigHalt, 0, "rst2_halted");
        want(0, SigIhc, 0, "rst2_ihit_cnt");
        want(0, SigIsc, 0, "rst2_istall_cnt");
        want(0, SigIren, 0, "rst2_iren");
        step();
        want(0, SigIren, 1, "rst2_iren_run");
        bus.MemRead = 1'b1;
        step();
        bus.MemRead = 1'b0;
        rst         = 1'b1;
        want(0, SigDren, 1, "rst3_dren_pre");
        want(0, SigIhc, 1, "rst3_ihit_pre");
        step();
        rst = 1'b0;
        want(0, SigDren, 0, "rst3_dren_drop");
        want(0, SigIren, 0, "rst3_iren");
        want(0, SigIhc, 0, "rst3_ihit_cnt");
        want(0, SigDsc, 0, "rst3_dstall_cnt");
        step();

        // Halt with no data request outstanding
        want(0, SigIren, 1, "h_iren_run");
        bus.is_halted = 1'b1;
        step();
        bus.is_halted = 1'b0;
        want(0, SigHalt, 1, "h_halted");
        want(0, SigIren, 0, "h_iren_off");
        step();

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 5 && sb.size() != 0; w++) step();
        #2;
        while (sb.size() != 0) begin
            n_chk++;
            $display("FAIL %s never_checked actual=none required=%0d", sb[0].name, sb[0].val);
            sb.delete(0);
        end

        // HALT is terminal: direct checks of the final state
        n_chk++;
        if (bus.halted === 1'b1) n_pass++;
        else $display("FAIL final_halted actual=%0b required=1", bus.halted);
        n_chk++;
        if (bus.imemREN === 1'b0) n_pass++;
        else $display("FAIL final_iren actual=%0b required=0", bus.imemREN);
        n_chk++;
        if (bus.dmemREN === 1'b0) n_pass++;
        else $display("FAIL final_dren actual=%0b required=0", bus.dmemREN);
        n_chk++;
        if (bus.dmemWEN === 1'b0) n_pass++;
        else $display("FAIL final_dwen actual=%0b required=0", bus.dmemWEN);
        n_chk++;
        if (bus.timeout === 1'b0) n_pass++;
        else $display("FAIL final_timeout actual=%0b required=0", bus.timeout);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
